muldiv_ctrl: RTL

//  Multi-cycle multiply/divide sequencer for the EX stage. Accepts MULT/MULTU/DIV/DIVU
//  ops from EX and runs a registered multiplier (MUL_LAT stages) or a radix-2 iterative divider.

---
 rtl/muldiv_ctrl_pkg.sv | 32 +++
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_ctrl_div_iter.sv | 48 ++++
 rtl/muldiv_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the EX-stage multiply/divide sequencer: op encodings,
// FSM states, result word type and the divider iteration count.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  typedef logic [63:0] doubleword_t;

  localparam int MD_DIV_CYCLES = 32;

  // Signed ops take operand magnitudes and fix the result sign afterwards.
  function automatic logic is_signed_md(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_mul_md(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX <-> multiply/divide sequencer handshake: request, operands, pipeline
// control and the {hi,lo} result.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic        start;
  md_op_t      op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        hold;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, opa, opb, flush, hold,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, opa, opb, flush, hold,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring radix-2 unsigned divider: init loads the operands, each step
// shifts one dividend bit into the partial remainder and trial-subtracts.
module muldiv_ctrl_div_iter (
  input  logic        clk,
  input  logic        init_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] dvs_q;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic [31:0] quot_nx;

  // One shift-subtract iteration; a borrow in bit 32 means the divisor did not fit.
  always_comb begin
    rem_sh  = {rem_q, quot_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    rem_nx  = rem_sh[31:0];
    quot_nx = {quot_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_nx  = diff[31:0];
      quot_nx = {quot_q[30:0], 1'b1};
    end
  end

  // Remainder/quotient registers; dividend bits shift out of quot_q as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (init_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multi-cycle multiply/divide sequencer. Owns the FSM, iteration
// counter, sign handling, the multiplier pipe and the hi/lo result registers.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  md
);

  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'(MD_DIV_CYCLES - 1);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        fix_q, fix_d;
  logic        accept;
  logic        ld_mul, ld_div, ld_dz;
  logic        div_step;
  logic        sgn_c;
  logic [31:0] a_mag_c, b_mag_c;
  logic [31:0] a_mag_q, b_mag_q;
  logic        neg_res_q, neg_rem_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] quot, rem;
  doubleword_t mul_mag_c;
  doubleword_t mul_out;
  doubleword_t mul_res;

  function automatic logic [31:0] cond_neg32(logic [31:0] v, logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic doubleword_t cond_neg64(doubleword_t v, logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign accept  = (state_q == ST_IDLE) && md.start && !md.flush;
  assign sgn_c   = is_signed_md(md.op);
  assign a_mag_c = cond_neg32(md.opa, sgn_c && md.opa[31]);
  assign b_mag_c = cond_neg32(md.opb, sgn_c && md.opb[31]);

  // Operand magnitudes and result-sign flags captured at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_mag_q   <= a_mag_c;
      b_mag_q   <= b_mag_c;
      neg_res_q <= sgn_c && (md.opa[31] ^ md.opb[31]);
      neg_rem_q <= sgn_c && md.opa[31];
    end
  end

  // ---- multiplier: unsigned 64-bit product of magnitudes, MUL_LAT stages to hi/lo ----
  assign mul_mag_c = 64'(a_mag_q) * 64'(b_mag_q);

  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_out = mul_mag_c;
  end else begin : g_mul_pipe
    doubleword_t mul_p_q [MUL_LAT-1];
    // Free-running product pipe; operands stay stable for the whole MUL state.
    always_ff @(posedge clk) begin
      mul_p_q[0] <= mul_mag_c;
      for (int k = 1; k < MUL_LAT - 1; k++) mul_p_q[k] <= mul_p_q[k-1];
    end
    assign mul_out = mul_p_q[MUL_LAT-2];
  end

  assign mul_res = cond_neg64(mul_out, neg_res_q);

  // ---- divider: initialised on acceptance, one step per DIV cycle until the fixup cycle ----
  muldiv_ctrl_div_iter u_div (
    .clk        (clk),
    .init_i     (accept && !is_mul_md(md.op)),
    .step_i     (div_step),
    .dividend_i (a_mag_c),
    .divisor_i  (b_mag_c),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // FSM state, iteration counter and divide-fixup flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fix_q   <= fix_d;
    end
  end

  // Next state, counter and result-load strobes; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fix_d    = fix_q;
    ld_mul   = 1'b0;
    ld_div   = 1'b0;
    ld_dz    = 1'b0;
    div_step = 1'b0;
    if (md.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      fix_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (md.start) begin
            cnt_d = '0;
            fix_d = 1'b0;
            if (is_mul_md(md.op)) begin
              state_d = ST_MUL;
            end else if (md.opb == 32'd0) begin
              state_d = ST_DONE;
              ld_dz   = 1'b1;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d = ST_DONE;
            ld_mul  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        ST_DIV: begin
          if (fix_q) begin
            state_d = ST_DONE;
            ld_div  = 1'b1;
            fix_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            div_step = 1'b1;
            if (cnt_q == DIV_LAST) fix_d = 1'b1;
            else                   cnt_d = cnt_q + 5'd1;
          end
        end
        ST_DONE: begin
          if (!md.hold) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // hi/lo registers: written only when entering DONE with a completed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (ld_dz) begin
      hi_q <= md.opa;
      lo_q <= 32'hFFFF_FFFF;
    end else if (ld_mul) begin
      hi_q <= mul_res[63:32];
      lo_q <= mul_res[31:0];
    end else if (ld_div) begin
      hi_q <= cond_neg32(rem, neg_rem_q);
      lo_q <= cond_neg32(quot, neg_res_q);
    end
  end

  assign md.busy = !md.flush && (((state_q == ST_IDLE) && md.start) ||
                                 (state_q == ST_MUL) || (state_q == ST_DIV));
  assign md.done = (state_q == ST_DONE);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
